// File: rtl/parity_pkg.sv
// Shared definitions for the parity-protected serial path: receiver state
// encoding, parity-sense constants and the error-counter saturation helper.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    // Increment that sticks at ERR_CNT_MAX instead of wrapping.
    function automatic logic [7:0] err_cnt_sat_inc(input logic [7:0] cnt);
        logic [7:0] res;
        if (cnt == ERR_CNT_MAX) begin
            res = cnt;
        end else begin
            res = cnt + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/parity_check_rx_parity_calc.sv
// XOR reduction with odd/even select, shared by the parity generator and checker.
// Over data alone it yields the parity bit to send; over data+parity it yields 1 on mismatch.
module parity_calc #(
    parameter int W = 9
) (
    input  logic [W-1:0] vec_i,
    input  logic         odd_sel_i,
    output logic         par_o
);

    assign par_o = (^vec_i) ^ odd_sel_i;

endmodule

// File: rtl/parity_check_rx.sv
// Serial deframer/checker: start, DATA_W data bits LSB first, parity, stop.
// Delivers words with a parity flag, pulses on framing errors, counts both kinds of error.
module parity_check_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              sin,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic [7:0]        err_count
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              mismatch_q, mismatch_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              par_mismatch_s;

    // The parity bit is still on sin while in PARITY, so check it together with the assembled word.
    parity_calc #(
        .W (DATA_W + 1)
    ) u_parity_calc (
        .vec_i     ({shreg_q, sin}),
        .odd_sel_i (PARITY_ODD),
        .par_o     (par_mismatch_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the machine only advances on bit strobes.
    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY;
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: shift/index datapath and the stop-bit result pulses.
    always_comb begin
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        mismatch_d   = mismatch_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q;
                    end
                end
                DATA: begin
                    shreg_d[idx_q] = sin;
                    idx_d          = idx_q + IDX_W'(1);
                end
                PARITY: begin
                    mismatch_d = par_mismatch_s;
                end
                STOP: begin
                    // A low stop bit is a framing error; it is not reused as the next start bit.
                    if (sin) begin
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                        parity_err_d = mismatch_q;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
                default: begin
                    idx_d = '0;
                end
            endcase
        end else begin
            idx_d = idx_q;
        end
    end

    // Error counter: counts the registered error pulses, clear has priority.
    always_comb begin
        err_count_d = err_count_q;
        if (clr_err) begin
            err_count_d = 8'd0;
        end else if (parity_err_q || frame_err_q) begin
            err_count_d = err_cnt_sat_inc(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            shreg_q      <= '0;
            mismatch_q   <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            mismatch_q   <= mismatch_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_parity_check_rx.sv
// Bench for parity_check_rx: an even-parity and an odd-parity receiver share one serial line
// and are checked against a frame-level model of word delivery, error flags and error counts.
module tb_parity_check_rx;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         bit_en;
    logic         sin;
    logic         clr_err;
    logic [W-1:0] dout_e, dout_o;
    logic         dv_e, dv_o, pe_e, pe_o, fe_e, fe_o;
    logic [7:0]   cnt_e, cnt_o;

    int           checks;
    int           errors;
    int           exp_cnt [2];
    int           pend    [2];
    logic [W-1:0] exp_dout[2];

    parity_check_rx #(.DATA_W(W), .PARITY_ODD(1'b0)) dut_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .sin        (sin),
        .clr_err    (clr_err),
        .data_out   (dout_e),
        .data_valid (dv_e),
        .parity_err (pe_e),
        .frame_err  (fe_e),
        .err_count  (cnt_e)
    );

    parity_check_rx #(.DATA_W(W), .PARITY_ODD(1'b1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_en     (bit_en),
        .sin        (sin),
        .clr_err    (clr_err),
        .data_out   (dout_o),
        .data_valid (dv_o),
        .parity_err (pe_o),
        .frame_err  (fe_o),
        .err_count  (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic edv, input logic epe, input logic efe);
        logic [W-1:0] d;
        logic         v, p, f;
        logic [7:0]   c;
        if (k == 0) begin
            d = dout_e; v = dv_e; p = pe_e; f = fe_e; c = cnt_e;
        end else begin
            d = dout_o; v = dv_o; p = pe_o; f = fe_o; c = cnt_o;
        end
        chk($sformatf("dut%0d data_out", k),   32'(d), 32'(exp_dout[k]));
        chk($sformatf("dut%0d data_valid", k), 32'(v), 32'(edv));
        chk($sformatf("dut%0d parity_err", k), 32'(p), 32'(epe));
        chk($sformatf("dut%0d frame_err", k),  32'(f), 32'(efe));
        chk($sformatf("dut%0d err_count", k),  32'(c), 32'(exp_cnt[k]));
    endtask

    // Errors from the previous frame become visible in err_count one clock after their pulse.
    task automatic commit();
        for (int k = 0; k < 2; k++) begin
            exp_cnt[k] = (exp_cnt[k] + pend[k] > 255) ? 255 : exp_cnt[k] + pend[k];
            pend[k]    = 0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_cnt[k]  = 0;
            pend[k]     = 0;
            exp_dout[k] = '0;
        end
    endtask

    // Drives one frame with one strobe every `period` clocks, then checks the stop-bit result.
    task automatic send_frame(input logic [W-1:0] d, input logic p, input logic stop, input int period);
        logic [W+2:0] bits;
        logic         mm [2];
        bits = {stop, p, d, 1'b0};
        commit();
        for (int i = 0; i < W + 3; i++) begin
            repeat (period - 1) @(negedge clk);
            bit_en = 1'b1;
            sin    = bits[i];
            @(negedge clk);
            bit_en = 1'b0;
            sin    = 1'b1;
        end
        mm[0] = (($countones(d) + int'(p)) % 2) != 0;
        mm[1] = (($countones(d) + int'(p)) % 2) != 1;
        for (int k = 0; k < 2; k++) begin
            if (stop) begin
                exp_dout[k] = d;
                check_dut(k, 1'b1, mm[k], 1'b0);
                pend[k] = mm[k] ? 1 : 0;
            end else begin
                check_dut(k, 1'b0, 1'b0, 1'b1);
                pend[k] = 1;
            end
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        commit();
        check_dut(0, 1'b0, 1'b0, 1'b0);
        check_dut(1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         rp, rs;
        int           per;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        bit_en  = 1'b0;
        sin     = 1'b1;
        clr_err = 1'b0;
        model_reset();

        #2 rst_n = 1'b0;
        @(negedge clk);
        check_dut(0, 1'b0, 1'b0, 1'b0);
        check_dut(1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean word, then wrong and right parity on the even receiver.
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        idle_check();
        send_frame(8'h07, 1'b0, 1'b1, 1);
        idle_check();
        send_frame(8'h07, 1'b1, 1'b1, 1);
        idle_check();

        // Low stop bit: framing error, previous word retained.
        send_frame(8'h3C, 1'b0, 1'b0, 1);
        idle_check();

        // Sparse strobes: every 4th clock.
        send_frame(8'hFF, 1'b1, 1'b1, 4);
        idle_check();

        // Start bit on the strobe right after the stop bit.
        send_frame(8'h12, 1'b0, 1'b1, 1);
        send_frame(8'h34, 1'b1, 1'b1, 1);
        idle_check();

        // Reset in the middle of a frame discards it without counting an error.
        bit_en = 1'b1;
        sin    = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sin = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst_n  = 1'b0;
        bit_en = 1'b0;
        sin    = 1'b1;
        model_reset();
        #1;
        check_dut(0, 1'b0, 1'b0, 1'b0);
        check_dut(1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_dut(0, 1'b0, 1'b0, 1'b0);
        check_dut(1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        idle_check();

        // Random frames, strobe spacing and occasional stop-bit errors.
        for (int n = 0; n < 40; n++) begin
            rd  = W'($urandom);
            rp  = 1'($urandom_range(0, 1));
            rs  = ($urandom_range(0, 5) != 0);
            per = int'($urandom_range(1, 3));
            send_frame(rd, rp, rs, per);
            if ($urandom_range(0, 1) == 1) begin
                idle_check();
            end
        end

        // Drive the even receiver's counter into saturation.
        for (int n = 0; n < 300; n++) begin
            send_frame(8'h07, 1'b0, 1'b1, 1);
        end
        idle_check();

        // Clear lands on the same clock as one more increment.
        send_frame(8'h07, 1'b0, 1'b1, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_cnt[k] = 0;
            pend[k]    = 0;
        end
        check_dut(0, 1'b0, 1'b0, 1'b0);
        check_dut(1, 1'b0, 1'b0, 1'b0);
        idle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
